// File: rtl/assembler_scan_sequencer_if.sv
// ============================================================================
// Module      : assembler_scan_sequencer_if (with assembler_scan_pkg)
// Description : Phase type plus buffer-read / assembler handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package assembler_scan_pkg;
    typedef enum logic [2:0] {
        IDLE                = 3'd0,
        PC_MAPPING          = 3'd1,
        INSTRUCTION_MAPPING = 3'd2,
        SUCCESS             = 3'd3,
        ERROR               = 3'd4
    } assembler_state_t;
endpackage

interface assembler_scan_sequencer_if #(
    parameter int CHAR_PER_LINE = 64,
    parameter int NUMBER_LINES  = 256
);
    import assembler_scan_pkg::*;

    localparam int ADDR_W = $clog2(CHAR_PER_LINE * NUMBER_LINES);
    localparam int LINE_W = $clog2(NUMBER_LINES);
    localparam int COL_W  = $clog2(CHAR_PER_LINE);

    logic              start_in;
    logic              te_busy_in;
    logic              rd_en_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [7:0]        rd_data_in;
    logic              asm_rst_out;
    logic              new_line_out;
    logic              new_char_out;
    logic [7:0]        char_out;
    logic [LINE_W-1:0] line_count_out;
    logic [COL_W-1:0]  char_count_out;
    logic              line_done_in;
    logic              line_error_in;
    assembler_state_t  phase_out;
    logic              done_out;

    modport master (
        input  start_in, te_busy_in, rd_data_in, line_done_in, line_error_in,
        output rd_en_out, rd_addr_out, asm_rst_out, new_line_out, new_char_out,
               char_out, line_count_out, char_count_out, phase_out, done_out
    );

    modport slave (
        output start_in, te_busy_in, rd_data_in, line_done_in, line_error_in,
        input  rd_en_out, rd_addr_out, asm_rst_out, new_line_out, new_char_out,
               char_out, line_count_out, char_count_out, phase_out, done_out
    );
endinterface

`default_nettype wire

// File: rtl/assembler_scan_sequencer.sv
// ============================================================================
// Module      : assembler_scan_sequencer
// Description : Two-pass scan of the editor buffer feeding the assembler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module assembler_scan_sequencer
    import assembler_scan_pkg::*;
#(
    parameter int CHAR_PER_LINE = 64,
    parameter int NUMBER_LINES  = 256,
    parameter int READ_LATENCY  = 2
) (
    input  wire logic                     clk_in,
    input  wire logic                     rst_n_in,
    assembler_scan_sequencer_if.master    bus
);

    localparam int ADDR_W = $clog2(CHAR_PER_LINE * NUMBER_LINES);
    localparam int LINE_W = $clog2(NUMBER_LINES);
    localparam int COL_W  = $clog2(CHAR_PER_LINE);
    localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    localparam logic [COL_W-1:0]  c_COL_LAST  = COL_W'(CHAR_PER_LINE - 1);
    localparam logic [LINE_W-1:0] c_LINE_LAST = LINE_W'(NUMBER_LINES - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LINE    = 3'd1,
        S_READ    = 3'd2,
        S_WAIT    = 3'd3,
        S_DELIVER = 3'd4,
        S_CHECK   = 3'd5,
        S_END     = 3'd6
    } state_t;

    state_t            r_state,     w_state_next;
    assembler_state_t  r_phase,     w_phase_next;
    logic [LINE_W-1:0] r_line,      w_line_next;
    logic [COL_W-1:0]  r_col,       w_col_next;
    logic [WAIT_W-1:0] r_wait,      w_wait_next;
    logic [7:0]        r_char,      w_char_next;
    logic              r_done_seen, w_done_seen_next;
    logic              r_asm_rst,   w_asm_rst_next;
    logic              r_done,      w_done_next;

    logic              w_rd_en;
    logic              w_new_line;
    logic              w_new_char;
    logic              w_abort;
    logic              w_line_over;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_phase     <= IDLE;
            r_line      <= '0;
            r_col       <= '0;
            r_wait      <= '0;
            r_char      <= '0;
            r_done_seen <= 1'b0;
            r_asm_rst   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_phase     <= w_phase_next;
            r_line      <= w_line_next;
            r_col       <= w_col_next;
            r_wait      <= w_wait_next;
            r_char      <= w_char_next;
            r_done_seen <= w_done_seen_next;
            r_asm_rst   <= w_asm_rst_next;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_phase_next     = r_phase;
        w_line_next      = r_line;
        w_col_next       = r_col;
        w_wait_next      = r_wait;
        w_char_next      = r_char;
        w_done_seen_next = r_done_seen;
        w_asm_rst_next   = 1'b0;
        w_done_next      = 1'b0;
        w_rd_en          = 1'b0;
        w_new_line       = 1'b0;
        w_new_char       = 1'b0;
        w_abort          = bus.line_error_in &&
                           (r_phase == PC_MAPPING || r_phase == INSTRUCTION_MAPPING);
        w_line_over      = r_done_seen || bus.line_done_in || (r_col == c_COL_LAST);

        // A restart beats everything, including a same-cycle error
        if (bus.start_in) begin
            w_state_next     = S_LINE;
            w_phase_next     = PC_MAPPING;
            w_line_next      = '0;
            w_col_next       = '0;
            w_wait_next      = '0;
            w_done_seen_next = 1'b0;
            w_asm_rst_next   = 1'b1;
        end else if (w_abort) begin
            w_state_next     = S_IDLE;
            w_phase_next     = ERROR;
            w_done_seen_next = 1'b0;
            w_done_next      = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_LINE: begin
                    w_new_line   = 1'b1;
                    w_state_next = S_READ;
                end
                S_READ: begin
                    if (!bus.te_busy_in) begin
                        w_rd_en      = 1'b1;
                        w_wait_next  = '0;
                        w_state_next = (READ_LATENCY > 1) ? S_WAIT : S_DELIVER;
                    end
                end
                // The read is already issued; terminal activity cannot cancel it
                S_WAIT: begin
                    if (r_wait == c_WAIT_LAST) begin
                        w_state_next = S_DELIVER;
                    end else begin
                        w_wait_next = r_wait + WAIT_W'(1);
                    end
                end
                S_DELIVER: begin
                    w_char_next      = bus.rd_data_in;
                    w_done_seen_next = r_done_seen || bus.line_done_in;
                    w_state_next     = S_CHECK;
                end
                S_CHECK: begin
                    w_new_char = 1'b1;
                    if (w_line_over) begin
                        w_col_next       = '0;
                        w_done_seen_next = 1'b0;
                        if (r_line == c_LINE_LAST) begin
                            w_state_next = S_END;
                        end else begin
                            w_line_next  = r_line + LINE_W'(1);
                            w_state_next = S_LINE;
                        end
                    end else begin
                        w_col_next   = r_col + COL_W'(1);
                        w_state_next = S_READ;
                    end
                end
                // Second pass keeps the label table, so no assembler reset here
                S_END: begin
                    if (r_phase == PC_MAPPING) begin
                        w_phase_next = INSTRUCTION_MAPPING;
                        w_line_next  = '0;
                        w_col_next   = '0;
                        w_state_next = S_LINE;
                    end else begin
                        w_phase_next = SUCCESS;
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign bus.rd_en_out      = w_rd_en;
    assign bus.rd_addr_out    = ADDR_W'(r_line) * ADDR_W'(CHAR_PER_LINE) + ADDR_W'(r_col);
    assign bus.asm_rst_out    = r_asm_rst;
    assign bus.new_line_out   = w_new_line;
    assign bus.new_char_out   = w_new_char;
    assign bus.char_out       = r_char;
    assign bus.line_count_out = r_line;
    assign bus.char_count_out = r_col;
    assign bus.phase_out      = r_phase;
    assign bus.done_out       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_assembler_scan_sequencer.sv
// ============================================================================
// Module      : tb_assembler_scan_sequencer
// Description : Directed self-checking bench for assembler_scan_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_assembler_scan_sequencer;
    import assembler_scan_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    assembler_scan_sequencer_if #(.CHAR_PER_LINE(64), .NUMBER_LINES(256)) ifm ();
    assembler_scan_sequencer_if #(.CHAR_PER_LINE(8),  .NUMBER_LINES(4))   ifs ();

    assembler_scan_sequencer #(.CHAR_PER_LINE(64), .NUMBER_LINES(256), .READ_LATENCY(2)) u_dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifm)
    );

    assembler_scan_sequencer #(.CHAR_PER_LINE(8), .NUMBER_LINES(4), .READ_LATENCY(3)) u_dut_small (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifs)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Buffer model for the main DUT: data only valid exactly 2 cycles after rd_en
    logic [7:0] mem [0:16383];
    logic [7:0] m_d0, m_d1;
    logic       m_v0 = 1'b0, m_v1 = 1'b0;
    always @(posedge clk) begin
        m_v0 <= ifm.rd_en_out;
        m_d0 <= mem[ifm.rd_addr_out];
        m_v1 <= m_v0;
        m_d1 <= m_d0;
    end
    assign ifm.rd_data_in = m_v1 ? m_d1 : 8'hEE;

    logic m_start = 1'b0, m_busy = 1'b0, m_err = 1'b0;
    assign ifm.start_in      = m_start;
    assign ifm.te_busy_in    = m_busy;
    assign ifm.line_error_in = m_err;
    assign ifm.line_done_in  = ifm.new_char_out && (ifm.char_out == 8'h3B || ifm.char_out == 8'h00);

    // Buffer model for the small DUT: latency 3, byte at address a holds a+1
    logic [7:0] s_d [0:2];
    logic       s_v [0:2];
    initial for (int i = 0; i < 3; i++) s_v[i] = 1'b0;
    always @(posedge clk) begin
        s_v[0] <= ifs.rd_en_out;
        s_d[0] <= 8'(ifs.rd_addr_out) + 8'd1;
        s_v[1] <= s_v[0]; s_d[1] <= s_d[0];
        s_v[2] <= s_v[1]; s_d[2] <= s_d[1];
    end
    assign ifs.rd_data_in = s_v[2] ? s_d[2] : 8'hEE;

    logic s_start = 1'b0;
    assign ifs.start_in      = s_start;
    assign ifs.te_busy_in    = 1'b0;
    assign ifs.line_error_in = 1'b0;
    assign ifs.line_done_in  = 1'b0;

    int cnt_nl_pc, cnt_nl_in, cnt_nc_pc, cnt_nc_in, cnt_nc_all;
    int cnt_rd, cnt_done, cnt_asm, l0_pc, l0_in;
    logic [7:0] seq_pc [0:63];
    logic [7:0] seq_in [0:63];
    int s_nl_pc, s_nl_in, s_nc_pc, s_nc_in, s_seq_err, s_max_addr;
    logic [4:0] s_idx;

    task automatic clear_counts();
        cnt_nl_pc = 0; cnt_nl_in = 0; cnt_nc_pc = 0; cnt_nc_in = 0; cnt_nc_all = 0;
        cnt_rd = 0; cnt_done = 0; cnt_asm = 0; l0_pc = 0; l0_in = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifm.new_line_out) begin
                if (ifm.phase_out == PC_MAPPING) cnt_nl_pc++;
                else if (ifm.phase_out == INSTRUCTION_MAPPING) cnt_nl_in++;
            end
            if (ifm.new_char_out) begin
                cnt_nc_all++;
                if (ifm.phase_out == PC_MAPPING) begin
                    cnt_nc_pc++;
                    if (ifm.line_count_out == 0) begin seq_pc[ifm.char_count_out] = ifm.char_out; l0_pc++; end
                end else if (ifm.phase_out == INSTRUCTION_MAPPING) begin
                    cnt_nc_in++;
                    if (ifm.line_count_out == 0) begin seq_in[ifm.char_count_out] = ifm.char_out; l0_in++; end
                end
            end
            if (ifm.rd_en_out)   cnt_rd++;
            if (ifm.done_out)    cnt_done++;
            if (ifm.asm_rst_out) cnt_asm++;

            if (ifs.new_line_out) begin
                if (ifs.phase_out == PC_MAPPING) s_nl_pc++; else s_nl_in++;
            end
            if (ifs.rd_en_out && int'(ifs.rd_addr_out) > s_max_addr) s_max_addr = int'(ifs.rd_addr_out);
            if (ifs.new_char_out) begin
                if (ifs.phase_out == PC_MAPPING) s_nc_pc++; else s_nc_in++;
                if (ifs.char_out != {3'b000, s_idx} + 8'd1 || ifs.char_count_out != s_idx[2:0] ||
                    ifs.line_count_out != s_idx[4:3]) s_seq_err++;
                s_idx = s_idx + 5'd1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 m_start = 1'b1;
        @(posedge clk); #1 m_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ifm.done_out) begin seen = 1'b1; break; end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_instr_line(input string tag, input int line);
        bit seen = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (ifm.phase_out == INSTRUCTION_MAPPING && int'(ifm.line_count_out) == line) begin seen = 1'b1; break; end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    string exp_l0 = "addi x1,x0,5;";

    initial begin
        int mism, bad, seen;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        for (int i = 0; i < exp_l0.len(); i++) mem[i] = exp_l0[i];
        clear_counts();
        s_nl_pc = 0; s_nl_in = 0; s_nc_pc = 0; s_nc_in = 0; s_seq_err = 0; s_max_addr = 0; s_idx = '0;

        // Reset state
        #12;
        check("rst_phase",   32'(ifm.phase_out), 32'(IDLE));
        check("rst_rd_en",   32'(ifm.rd_en_out), 32'd0);
        check("rst_addr",    32'(ifm.rd_addr_out), 32'd0);
        check("rst_pulses",  32'({ifm.asm_rst_out, ifm.new_line_out, ifm.new_char_out, ifm.done_out}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // T1: two identical passes, then SUCCESS
        pulse_start();
        check("t1_asm_rst", 32'(ifm.asm_rst_out), 32'd1);
        check("t1_phase_pc", 32'(ifm.phase_out), 32'(PC_MAPPING));
        wait_done("t1_done", 5000);
        check("t1_phase_ok", 32'(ifm.phase_out), 32'(SUCCESS));
        @(posedge clk); #1;
        check("t1_done_cnt", 32'(cnt_done), 32'd1);
        check("t1_asm_cnt",  32'(cnt_asm),  32'd1);
        check("t1_nl_pc",    32'(cnt_nl_pc), 32'd256);
        check("t1_nl_in",    32'(cnt_nl_in), 32'd256);
        check("t1_nc_pc",    32'(cnt_nc_pc), 32'd268);
        check("t1_nc_in",    32'(cnt_nc_in), 32'd268);
        check("t1_l0_len",   32'(l0_pc + l0_in), 32'd26);
        mism = 0;
        for (int i = 0; i < 13; i++) begin
            if (seq_pc[i] !== exp_l0[i]) mism++;
            if (seq_in[i] !== exp_l0[i]) mism++;
        end
        check("t1_l0_chars", 32'(mism), 32'd0);

        // T2: small instance, no line_done, full lines and last address
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (ifs.done_out) begin seen = 1; break; end
        end
        check("t2_done", 32'(seen), 32'd1);
        check("t2_phase", 32'(ifs.phase_out), 32'(SUCCESS));
        @(posedge clk); #1;
        check("t2_nl", 32'({s_nl_pc[15:0], s_nl_in[15:0]}), {16'd4, 16'd4});
        check("t2_nc", 32'({s_nc_pc[15:0], s_nc_in[15:0]}), {16'd32, 16'd32});
        check("t2_seq", 32'(s_seq_err), 32'd0);
        check("t2_max_addr", 32'(s_max_addr), 32'd31);

        // T3: terminal owns the port while the first read is pending
        clear_counts();
        pulse_start();
        m_busy = 1'b1;
        bad = 0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (ifm.rd_en_out) bad++;
        end
        check("t3_stall", 32'(bad), 32'd0);
        @(posedge clk); #1 m_busy = 1'b0;
        @(negedge clk);
        check("t3_rd_en", 32'(ifm.rd_en_out), 32'd1);
        check("t3_addr",  32'(ifm.rd_addr_out), 32'd0);
        @(posedge clk); #1 m_busy = 1'b1;
        @(negedge clk);
        check("t3_wait_rd", 32'(ifm.rd_en_out), 32'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("t3_char", 32'({ifm.new_char_out, ifm.char_out}), {23'd0, 1'b1, 8'h61});
        @(posedge clk); #1;
        check("t3_rd_cnt", 32'(cnt_rd), 32'd1);
        m_busy = 1'b0;
        wait_done("t3_done", 5000);

        // T4: error during pass 2 line 3
        pulse_start();
        wait_instr_line("t4_reach", 3);
        @(posedge clk); #1 m_err = 1'b1;
        @(posedge clk); #1 m_err = 1'b0;
        @(negedge clk);
        check("t4_phase_err", 32'(ifm.phase_out), 32'(ERROR));
        check("t4_done", 32'(ifm.done_out), 32'd1);
        @(posedge clk); #1 clear_counts();
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifm.phase_out != ERROR) bad++;
        end
        check("t4_hold", 32'(bad), 32'd0);
        check("t4_no_rd", 32'({cnt_rd[15:0], cnt_done[15:0]}), 32'd0);

        // T5: restart mid pass 2, then restart coincident with error
        pulse_start();
        wait_instr_line("t5_reach", 5);
        pulse_start();
        check("t5_asm_rst", 32'(ifm.asm_rst_out), 32'd1);
        check("t5_phase", 32'(ifm.phase_out), 32'(PC_MAPPING));
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ifm.rd_en_out) begin seen = 1; break; end
        end
        check("t5_rd_seen", 32'(seen), 32'd1);
        check("t5_addr", 32'(ifm.rd_addr_out), 32'd0);
        wait_instr_line("t5_reach2", 2);
        @(posedge clk); #1 begin m_start = 1'b1; m_err = 1'b1; end
        @(posedge clk); #1 begin m_start = 1'b0; m_err = 1'b0; end
        @(negedge clk);
        check("t5_coinc_phase", 32'(ifm.phase_out), 32'(PC_MAPPING));
        check("t5_coinc_pulses", 32'({ifm.asm_rst_out, ifm.done_out}), 32'b10);

        // T6: asynchronous reset while a read is in flight
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ifm.rd_en_out && ifm.char_count_out != 0) begin seen = 1; break; end
        end
        check("t6_rd_seen", 32'(seen), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("t6_phase", 32'(ifm.phase_out), 32'(IDLE));
        check("t6_state_out", 32'({ifm.char_out, 8'(ifm.line_count_out), 8'(ifm.char_count_out)}), 32'd0);
        check("t6_addr", 32'(ifm.rd_addr_out), 32'd0);
        check("t6_pulses", 32'({ifm.rd_en_out, ifm.asm_rst_out, ifm.new_line_out, ifm.new_char_out, ifm.done_out}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counts();
        repeat (20) @(posedge clk);
        #1;
        check("t6_quiet", 32'({cnt_nc_all[15:0], cnt_rd[15:0]}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
